// File: rtl/mem_burst_responder.sv
// Memory-side burst responder: serves fixed-length read/write bursts from a
// single-port synchronous RAM (1-cycle read latency) behind a byte-address window.
module mem_burst_responder #(
    parameter int                  DATABITS    = 32,
    parameter int                  ADDRBITS    = 32,
    parameter int                  RAMADDRBITS = 10,
    parameter int                  BURSTLEN    = 8,
    parameter logic [ADDRBITS-1:0] BASEADDR    = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDRBITS-1:0]    mem_addr,
    input  logic [DATABITS-1:0]    mem_in,
    input  logic                   mem_rdreq,
    input  logic                   mem_wrreq,
    output logic [DATABITS-1:0]    mem_out,
    output logic                   mem_out_valid,
    output logic [15:0]            mem_burstlen,
    output logic                   mem_err,
    output logic [RAMADDRBITS-1:0] ram_addr,
    output logic [DATABITS-1:0]    ram_wdata,
    output logic                   ram_we,
    input  logic [DATABITS-1:0]    ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RDRAIN,
        WRITE,
        GAP
    } state_t;

    localparam logic [15:0] LASTWORD = 16'(BURSTLEN - 1);

    state_t                state_q, state_d;
    logic [ADDRBITS-1:0]   addr_q, addr_d;
    logic [15:0]           wordCnt_q, wordCnt_d;
    logic [DATABITS-1:0]   wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  rdPend_q, rdOow_q;
    logic [DATABITS-1:0]   memOut_q;
    logic                  memOutValid_q;

    logic [ADDRBITS-1:0]   offset;
    logic [ADDRBITS-1:0]   wordIdx;
    logic                  inWindow;
    logic                  issuing;

    // Window test is done on the full-width word index so wrap-around below BASEADDR falls out.
    assign offset   = addr_q - BASEADDR;
    assign wordIdx  = offset >> 2;
    assign inWindow = (wordIdx >> RAMADDRBITS) == '0;
    assign issuing  = (state_q == READ) || (state_q == WRITE);

    assign ram_addr      = issuing ? wordIdx[RAMADDRBITS-1:0] : '0;
    assign ram_we        = (state_q == WRITE) && inWindow;
    assign ram_wdata     = (state_q == WRITE) ? wdata_q : '0;
    assign mem_out       = memOut_q;
    assign mem_out_valid = memOutValid_q;
    assign mem_err       = err_q;
    assign mem_burstlen  = 16'(BURSTLEN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wordCnt_q     <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            rdPend_q      <= 1'b0;
            rdOow_q       <= 1'b0;
            memOut_q      <= '0;
            memOutValid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wordCnt_q     <= wordCnt_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            rdPend_q      <= (state_q == READ);
            rdOow_q       <= !inWindow;
            memOut_q      <= (rdPend_q && !rdOow_q) ? ram_rdata : '0;
            memOutValid_q <= rdPend_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wordCnt_d = wordCnt_q;
        wdata_d   = wdata_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                wordCnt_d = '0;
                if (mem_rdreq) begin
                    addr_d  = mem_addr;
                    state_d = READ;
                    if (mem_wrreq) begin
                        err_d = 1'b1;
                    end
                end else if (mem_wrreq) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_in;
                    state_d = WRITE;
                end
            end
            READ, WRITE: begin
                addr_d = addr_q + ADDRBITS'(4);
                if (!inWindow) begin
                    err_d = 1'b1;
                end
                if (state_q == WRITE) begin
                    wdata_d = mem_in;
                end
                if (wordCnt_q == LASTWORD) begin
                    wordCnt_d = '0;
                    state_d   = (state_q == READ) ? RDRAIN : GAP;
                end else begin
                    wordCnt_d = wordCnt_q + 16'd1;
                end
            end
            // Two drain cycles cover the RAM latency plus the output register.
            RDRAIN: begin
                if (wordCnt_q == 16'd1) begin
                    wordCnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    wordCnt_d = wordCnt_q + 16'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
